// File: rtl/rvfi_trace_checker.sv
// Passive RVFI (NRET=1) consistency checker: order, PC chain, x0, shadow-regfile reads, mem masks.
// Verdicts and counters are registered one cycle after the record; the trace is never stalled.
module rvfi_trace_checker #(
    parameter logic [31:0] RESET_PC   = 32'h10000000,
    parameter int          CHECK_REGS = 1,
    parameter int          TRAP_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rvfi_valid,
    input  logic [63:0]           i_rvfi_order,
    input  logic [31:0]           i_rvfi_insn,
    input  logic                  i_rvfi_trap,
    input  logic [4:0]            i_rvfi_rs1_addr,
    input  logic [4:0]            i_rvfi_rs2_addr,
    input  logic [31:0]           i_rvfi_rs1_rdata,
    input  logic [31:0]           i_rvfi_rs2_rdata,
    input  logic [4:0]            i_rvfi_rd_addr,
    input  logic [31:0]           i_rvfi_rd_wdata,
    input  logic [31:0]           i_rvfi_pc_rdata,
    input  logic [31:0]           i_rvfi_pc_wdata,
    input  logic [3:0]            i_rvfi_mem_rmask,
    input  logic [3:0]            i_rvfi_mem_wmask,
    output logic [31:0]           o_retired_count,
    output logic [TRAP_CNT_W-1:0] o_trap_count,
    output logic                  o_error,
    output logic [2:0]            o_error_code,
    output logic [63:0]           o_error_order,
    output logic [31:0]           o_error_pc
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t                  state_q, state_d;
    logic [63:0]             exp_order_q, exp_order_d;
    logic [31:0]             exp_pc_q, exp_pc_d;
    logic                    exp_pc_vld_q, exp_pc_vld_d;
    logic [31:0]             retired_q, retired_d;
    logic [TRAP_CNT_W-1:0]   trap_cnt_q, trap_cnt_d;
    logic                    error_q, error_d;
    logic [2:0]              error_code_q, error_code_d;
    logic [63:0]             error_order_q, error_order_d;
    logic [31:0]             error_pc_q, error_pc_d;
    logic [31:1]             shadow_vld_q, shadow_vld_d;
    logic [31:0]             shadow_q [1:31];
    logic [31:0]             shadow_d [1:31];

    logic        accept, clean, viol;
    logic        chk_regs;
    logic        err_order, err_pc, err_x0, err_rs1, err_rs2, err_mask;
    logic [31:0] rs1_shadow, rs2_shadow;
    logic        rs1_known, rs2_known;
    logic [2:0]  viol_code;
    logic        unused_insn;

    assign unused_insn = ^i_rvfi_insn;

    // Lookups see only pre-update shadow state, so rd == rs1 compares against the old value.
    always_comb begin
        rs1_shadow = '0;
        rs2_shadow = '0;
        rs1_known  = 1'b0;
        rs2_known  = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (i_rvfi_rs1_addr == 5'(i)) begin
                rs1_shadow = shadow_q[i];
                rs1_known  = shadow_vld_q[i];
            end
            if (i_rvfi_rs2_addr == 5'(i)) begin
                rs2_shadow = shadow_q[i];
                rs2_known  = shadow_vld_q[i];
            end
        end
    end

    always_comb begin
        chk_regs  = (CHECK_REGS != 0) && !i_rvfi_trap;
        err_order = (i_rvfi_order != exp_order_q);
        err_pc    = exp_pc_vld_q && (i_rvfi_pc_rdata != exp_pc_q);
        err_x0    = (i_rvfi_rd_addr == 5'd0) && (i_rvfi_rd_wdata != 32'd0);
        err_rs1   = chk_regs && ((i_rvfi_rs1_addr == 5'd0) ? (i_rvfi_rs1_rdata != 32'd0)
                                 : (rs1_known && (i_rvfi_rs1_rdata != rs1_shadow)));
        err_rs2   = chk_regs && ((i_rvfi_rs2_addr == 5'd0) ? (i_rvfi_rs2_rdata != 32'd0)
                                 : (rs2_known && (i_rvfi_rs2_rdata != rs2_shadow)));
        err_mask  = (i_rvfi_mem_rmask != 4'd0) && (i_rvfi_mem_wmask != 4'd0);

        if (err_order)     viol_code = 3'd1;
        else if (err_pc)   viol_code = 3'd2;
        else if (err_x0)   viol_code = 3'd3;
        else if (err_rs1)  viol_code = 3'd4;
        else if (err_rs2)  viol_code = 3'd5;
        else if (err_mask) viol_code = 3'd6;
        else               viol_code = 3'd0;

        accept = i_rvfi_valid && (state_q != ERR);
        viol   = accept && (viol_code != 3'd0);
        clean  = accept && (viol_code == 3'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (viol) state_d = ERR; else if (clean) state_d = RUN;
            RUN:     if (viol) state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_comb begin
        exp_order_d   = exp_order_q;
        exp_pc_d      = exp_pc_q;
        exp_pc_vld_d  = exp_pc_vld_q;
        retired_d     = retired_q;
        trap_cnt_d    = trap_cnt_q;
        error_d       = error_q;
        error_code_d  = error_code_q;
        error_order_d = error_order_q;
        error_pc_d    = error_pc_q;
        shadow_vld_d  = shadow_vld_q;
        shadow_d      = shadow_q;

        if (viol) begin
            error_d       = 1'b1;
            error_code_d  = viol_code;
            error_order_d = i_rvfi_order;
            error_pc_d    = i_rvfi_pc_rdata;
        end else if (clean) begin
            exp_order_d = i_rvfi_order + 64'd1;
            if (i_rvfi_trap) begin
                // Trap target is not trustworthy; the next record re-anchors the PC chain.
                exp_pc_vld_d = 1'b0;
                if (trap_cnt_q != '1) trap_cnt_d = trap_cnt_q + 1'b1;
            end else begin
                exp_pc_d     = i_rvfi_pc_wdata;
                exp_pc_vld_d = 1'b1;
                retired_d    = retired_q + 32'd1;
                for (int i = 1; i < 32; i++) begin
                    if (i_rvfi_rd_addr == 5'(i)) begin
                        shadow_d[i]     = i_rvfi_rd_wdata;
                        shadow_vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exp_order_q   <= '0;
            exp_pc_q      <= RESET_PC;
            exp_pc_vld_q  <= 1'b1;
            retired_q     <= '0;
            trap_cnt_q    <= '0;
            error_q       <= 1'b0;
            error_code_q  <= '0;
            error_order_q <= '0;
            error_pc_q    <= '0;
            shadow_vld_q  <= '0;
        end else begin
            exp_order_q   <= exp_order_d;
            exp_pc_q      <= exp_pc_d;
            exp_pc_vld_q  <= exp_pc_vld_d;
            retired_q     <= retired_d;
            trap_cnt_q    <= trap_cnt_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
            error_order_q <= error_order_d;
            error_pc_q    <= error_pc_d;
            shadow_vld_q  <= shadow_vld_d;
        end
    end

    // Data needs no reset: entries are only trusted once their valid bit is set.
    always_ff @(posedge i_clk) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        o_retired_count = retired_q;
        o_trap_count    = trap_cnt_q;
        o_error         = error_q;
        o_error_code    = error_code_q;
        o_error_order   = error_order_q;
        o_error_pc      = error_pc_q;
    end

endmodule

// File: tb/tb_rvfi_trace_checker.sv
// Directed bench: two checkers share one trace; the second has register checks off and a 2-bit trap counter.
module tb_rvfi_trace_checker;

    localparam logic [31:0] RPC = 32'h10000000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_rvfi_valid;
    logic [63:0] i_rvfi_order;
    logic [31:0] i_rvfi_insn;
    logic        i_rvfi_trap;
    logic [4:0]  i_rvfi_rs1_addr, i_rvfi_rs2_addr, i_rvfi_rd_addr;
    logic [31:0] i_rvfi_rs1_rdata, i_rvfi_rs2_rdata, i_rvfi_rd_wdata;
    logic [31:0] i_rvfi_pc_rdata, i_rvfi_pc_wdata;
    logic [3:0]  i_rvfi_mem_rmask, i_rvfi_mem_wmask;

    logic [31:0] a_retired, b_retired;
    logic [15:0] a_trap;
    logic [1:0]  b_trap;
    logic        a_err, b_err;
    logic [2:0]  a_code, b_code;
    logic [63:0] a_order, b_order;
    logic [31:0] a_pc, b_pc;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    rvfi_trace_checker #(.RESET_PC(RPC), .CHECK_REGS(1), .TRAP_CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rvfi_valid(i_rvfi_valid), .i_rvfi_order(i_rvfi_order),
        .i_rvfi_insn(i_rvfi_insn), .i_rvfi_trap(i_rvfi_trap),
        .i_rvfi_rs1_addr(i_rvfi_rs1_addr), .i_rvfi_rs2_addr(i_rvfi_rs2_addr),
        .i_rvfi_rs1_rdata(i_rvfi_rs1_rdata), .i_rvfi_rs2_rdata(i_rvfi_rs2_rdata),
        .i_rvfi_rd_addr(i_rvfi_rd_addr), .i_rvfi_rd_wdata(i_rvfi_rd_wdata),
        .i_rvfi_pc_rdata(i_rvfi_pc_rdata), .i_rvfi_pc_wdata(i_rvfi_pc_wdata),
        .i_rvfi_mem_rmask(i_rvfi_mem_rmask), .i_rvfi_mem_wmask(i_rvfi_mem_wmask),
        .o_retired_count(a_retired), .o_trap_count(a_trap), .o_error(a_err),
        .o_error_code(a_code), .o_error_order(a_order), .o_error_pc(a_pc)
    );

    rvfi_trace_checker #(.RESET_PC(RPC), .CHECK_REGS(0), .TRAP_CNT_W(2)) dut_nr (
        .i_clk(i_clk), .i_rst(i_rst), .i_rvfi_valid(i_rvfi_valid), .i_rvfi_order(i_rvfi_order),
        .i_rvfi_insn(i_rvfi_insn), .i_rvfi_trap(i_rvfi_trap),
        .i_rvfi_rs1_addr(i_rvfi_rs1_addr), .i_rvfi_rs2_addr(i_rvfi_rs2_addr),
        .i_rvfi_rs1_rdata(i_rvfi_rs1_rdata), .i_rvfi_rs2_rdata(i_rvfi_rs2_rdata),
        .i_rvfi_rd_addr(i_rvfi_rd_addr), .i_rvfi_rd_wdata(i_rvfi_rd_wdata),
        .i_rvfi_pc_rdata(i_rvfi_pc_rdata), .i_rvfi_pc_wdata(i_rvfi_pc_wdata),
        .i_rvfi_mem_rmask(i_rvfi_mem_rmask), .i_rvfi_mem_wmask(i_rvfi_mem_wmask),
        .o_retired_count(b_retired), .o_trap_count(b_trap), .o_error(b_err),
        .o_error_code(b_code), .o_error_order(b_order), .o_error_pc(b_pc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic rec(input logic [63:0] ord, input logic [31:0] pc, input logic trap,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] rs1, input logic [31:0] r1d,
                       input logic [4:0] rs2, input logic [31:0] r2d);
        i_rvfi_valid     = 1'b1;
        i_rvfi_order     = ord;
        i_rvfi_insn      = 32'h00000013;
        i_rvfi_pc_rdata  = pc;
        i_rvfi_pc_wdata  = pc + 32'd4;
        i_rvfi_trap      = trap;
        i_rvfi_rd_addr   = rd;
        i_rvfi_rd_wdata  = wd;
        i_rvfi_rs1_addr  = rs1;
        i_rvfi_rs1_rdata = r1d;
        i_rvfi_rs2_addr  = rs2;
        i_rvfi_rs2_rdata = r2d;
        @(posedge i_clk); #1;
        i_rvfi_valid     = 1'b0;
    endtask

    task automatic plain(input logic [63:0] ord, input logic [31:0] pc);
        rec(ord, pc, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_retired"}, 64'(a_retired), 64'd0);
        chk({tag, "_trap"},    64'(a_trap),    64'd0);
        chk({tag, "_err"},     64'(a_err),     64'd0);
        chk({tag, "_code"},    64'(a_code),    64'd0);
        chk({tag, "_order"},   a_order,        64'd0);
        chk({tag, "_pc"},      64'(a_pc),      64'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_rvfi_valid = 1'b0; i_rvfi_order = '0; i_rvfi_insn = '0;
        i_rvfi_trap = 1'b0; i_rvfi_rs1_addr = '0; i_rvfi_rs2_addr = '0; i_rvfi_rd_addr = '0;
        i_rvfi_rs1_rdata = '0; i_rvfi_rs2_rdata = '0; i_rvfi_rd_wdata = '0;
        i_rvfi_pc_rdata = '0; i_rvfi_pc_wdata = '0; i_rvfi_mem_rmask = '0; i_rvfi_mem_wmask = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk_clear("reset");

        // Clean in-order stream, back to back
        plain(0, RPC); plain(1, RPC + 4); plain(2, RPC + 8);
        chk("seq_retired", 64'(a_retired), 64'd3);
        chk("seq_err", 64'(a_err), 64'd0);

        // First record off the reset PC
        do_reset();
        plain(0, RPC + 4);
        chk("pc_err", 64'(a_err), 64'd1);
        chk("pc_code", 64'(a_code), 64'd2);
        chk("pc_order", a_order, 64'd0);
        chk("pc_pc", 64'(a_pc), 64'(RPC + 4));
        plain(1, RPC + 8);
        chk("pc_frozen_count", 64'(a_retired), 64'd0);
        chk("pc_frozen_code", 64'(a_code), 64'd2);

        // Shadow read-after-write; rd == rs1 compares against the old value
        do_reset();
        rec(0, RPC,     1'b0, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 32'd0);
        rec(1, RPC + 4, 1'b0, 5'd5, 32'h00000001, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        chk("raw_same_rec_err", 64'(a_err), 64'd0);
        rec(2, RPC + 8, 1'b0, 5'd0, 32'd0, 5'd5, 32'hDEADBEEE, 5'd0, 32'd0);
        chk("rs1_code", 64'(a_code), 64'd4);
        chk("rs1_order", a_order, 64'd2);
        chk("rs1_pc", 64'(a_pc), 64'(RPC + 8));
        chk("rs1_nocheck_err", 64'(b_err), 64'd0);
        chk("rs1_nocheck_retired", 64'(b_retired), 64'd3);

        // Reset out of ERR clears the shadow: x5 read with any value is accepted
        do_reset();
        chk_clear("rst_from_err");
        rec(0, RPC, 1'b0, 5'd0, 32'd0, 5'd5, 32'h00001234, 5'd0, 32'd0);
        chk("post_rst_err", 64'(a_err), 64'd0);
        chk("post_rst_retired", 64'(a_retired), 64'd1);

        // Non-zero read of x0 through rs2
        do_reset();
        rec(0, RPC, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd5);
        chk("rs2_x0_code", 64'(a_code), 64'd5);
        chk("rs2_x0_nocheck_err", 64'(b_err), 64'd0);

        // Order skip together with an x0 write: order wins
        do_reset();
        plain(0, RPC);
        rec(2, RPC + 4, 1'b0, 5'd0, 32'd1, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("order_code", 64'(a_code), 64'd1);
        chk("order_order", a_order, 64'd2);

        // Plain x0 write
        do_reset();
        rec(0, RPC, 1'b0, 5'd0, 32'd7, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("x0_code", 64'(a_code), 64'd3);

        // Trap breaks the PC chain for exactly one record
        do_reset();
        plain(0, RPC); plain(1, RPC + 4); plain(2, RPC + 8);
        rec(3, RPC + 12, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        plain(4, 32'h40000000);
        chk("trap_err", 64'(a_err), 64'd0);
        chk("trap_count", 64'(a_trap), 64'd1);
        chk("trap_retired", 64'(a_retired), 64'd4);
        plain(5, 32'h40000008);
        chk("reanchor_code", 64'(a_code), 64'd2);
        chk("reanchor_pc", 64'(a_pc), 64'h40000008);
        chk("reanchor_order", a_order, 64'd5);

        // Trap counter saturation on the 2-bit instance
        do_reset();
        rec(0, RPC, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        for (int i = 1; i < 4; i++)
            rec(64'(i), 32'h20000000 + 32'(i * 256), 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("trap_wide", 64'(a_trap), 64'd4);
        chk("trap_sat", 64'(b_trap), 64'd3);
        chk("trap_sat_err", 64'(b_err), 64'd0);

        // Simultaneous load and store masks
        do_reset();
        i_rvfi_mem_rmask = 4'hF;
        i_rvfi_mem_wmask = 4'h1;
        plain(0, RPC);
        i_rvfi_mem_rmask = 4'h0;
        i_rvfi_mem_wmask = 4'h0;
        chk("mask_code", 64'(a_code), 64'd6);
        chk("mask_nocheck_code", 64'(b_code), 64'd6);

        // Idle cycles do not disturb an errored checker
        repeat (3) @(posedge i_clk);
        #1;
        chk("err_sticky", 64'(a_err), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
